// File: rtl/pipeline_pkg.sv
// Shared encodings for the five-stage core's pipeline registers.
// Writeback source and memory access size are carried between stages as these enums.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
// Used for the hazard-unit stall and bubble statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register; increments are dropped once the ceiling is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc_i && (count_r != COUNT_MAX)) begin
            count_r <= count_r + COUNT_ONE;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/execute_memory_pipe_reg.sv
// EX->MEM pipeline register with hold/bubble control, a valid bit, sub-word access
// size, a forwarding tap for the hazard unit and saturating stall/bubble counters.
module execute_memory_pipe_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_m_i,
    input  logic                      flush_m_i,
    input  logic                      valid_e_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_e_i,
    input  logic [DATA_WIDTH-1:0]     write_data_e_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_e_i,
    input  logic [DATA_WIDTH-1:0]     imm_ext_e_i,
    input  logic [REGISTER_WIDTH-1:0] rd_e_i,
    input  logic [1:0]                result_src_e_i,
    input  logic                      reg_write_e_i,
    input  logic                      mem_write_e_i,
    input  logic [1:0]                mem_size_e_i,
    input  logic                      mem_unsigned_e_i,
    output logic                      valid_m_o,
    output logic [DATA_WIDTH-1:0]     alu_result_m_o,
    output logic [DATA_WIDTH-1:0]     write_data_m_o,
    output logic [DATA_WIDTH-1:0]     pc_plus4_m_o,
    output logic [DATA_WIDTH-1:0]     imm_ext_m_o,
    output logic [REGISTER_WIDTH-1:0] rd_m_o,
    output logic [1:0]                result_src_m_o,
    output logic                      reg_write_m_o,
    output logic                      mem_write_m_o,
    output logic [1:0]                mem_size_m_o,
    output logic                      mem_unsigned_m_o,
    output logic [DATA_WIDTH-1:0]     fwd_data_m_o,
    output logic                      fwd_en_m_o,
    output logic                      load_pending_m_o,
    output logic [COUNT_WIDTH-1:0]    stall_count_o,
    output logic [COUNT_WIDTH-1:0]    bubble_count_o
);

    logic                      valid_r,        valid_s;
    logic [DATA_WIDTH-1:0]     alu_result_r,   alu_result_s;
    logic [DATA_WIDTH-1:0]     write_data_r,   write_data_s;
    logic [DATA_WIDTH-1:0]     pc_plus4_r,     pc_plus4_s;
    logic [DATA_WIDTH-1:0]     imm_ext_r,      imm_ext_s;
    logic [REGISTER_WIDTH-1:0] rd_r,           rd_s;
    result_src_t               result_src_r,   result_src_s;
    logic                      reg_write_r,    reg_write_s;
    logic                      mem_write_r,    mem_write_s;
    logic [1:0]                mem_size_r,     mem_size_s;
    logic                      mem_unsigned_r, mem_unsigned_s;
    logic                      rd_nonzero_s;
    logic                      stall_inc_s;
    logic                      bubble_inc_s;

    function automatic logic [DATA_WIDTH-1:0] fwd_select(
        input result_src_t           src,
        input logic [DATA_WIDTH-1:0] alu,
        input logic [DATA_WIDTH-1:0] pc4,
        input logic [DATA_WIDTH-1:0] imm
    );
        logic [DATA_WIDTH-1:0] sel;
        case (src)
            RES_PC4: sel = pc4;
            RES_IMM: sel = imm;
            default: sel = alu;   // loads forward nothing useful; alu keeps the mux small
        endcase
        return sel;
    endfunction

    // Next-entry select: flush beats stall, stall holds, otherwise load from EX.
    always_comb begin
        valid_s        = valid_r;
        alu_result_s   = alu_result_r;
        write_data_s   = write_data_r;
        pc_plus4_s     = pc_plus4_r;
        imm_ext_s      = imm_ext_r;
        rd_s           = rd_r;
        result_src_s   = result_src_r;
        reg_write_s    = reg_write_r;
        mem_write_s    = mem_write_r;
        mem_size_s     = mem_size_r;
        mem_unsigned_s = mem_unsigned_r;
        case ({flush_m_i, stall_m_i})
            2'b00: begin
                valid_s        = valid_e_i;
                alu_result_s   = alu_result_e_i;
                write_data_s   = write_data_e_i;
                pc_plus4_s     = pc_plus4_e_i;
                imm_ext_s      = imm_ext_e_i;
                rd_s           = rd_e_i;
                result_src_s   = result_src_t'(result_src_e_i);
                // side-effecting controls only travel with a real instruction
                reg_write_s    = reg_write_e_i & valid_e_i;
                mem_write_s    = mem_write_e_i & valid_e_i;
                mem_size_s     = mem_size_e_i;
                mem_unsigned_s = mem_unsigned_e_i;
            end
            2'b01: begin
                valid_s = valid_r;
            end
            default: begin
                valid_s        = 1'b0;
                alu_result_s   = {DATA_WIDTH{1'b0}};
                write_data_s   = {DATA_WIDTH{1'b0}};
                pc_plus4_s     = {DATA_WIDTH{1'b0}};
                imm_ext_s      = {DATA_WIDTH{1'b0}};
                rd_s           = {REGISTER_WIDTH{1'b0}};
                result_src_s   = RES_ALU;
                reg_write_s    = 1'b0;
                mem_write_s    = 1'b0;
                mem_size_s     = SIZE_BYTE;
                mem_unsigned_s = 1'b0;
            end
        endcase
    end

    // Pipeline entry register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r        <= 1'b0;
            alu_result_r   <= {DATA_WIDTH{1'b0}};
            write_data_r   <= {DATA_WIDTH{1'b0}};
            pc_plus4_r     <= {DATA_WIDTH{1'b0}};
            imm_ext_r      <= {DATA_WIDTH{1'b0}};
            rd_r           <= {REGISTER_WIDTH{1'b0}};
            result_src_r   <= RES_ALU;
            reg_write_r    <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_size_r     <= SIZE_BYTE;
            mem_unsigned_r <= 1'b0;
        end else begin
            valid_r        <= valid_s;
            alu_result_r   <= alu_result_s;
            write_data_r   <= write_data_s;
            pc_plus4_r     <= pc_plus4_s;
            imm_ext_r      <= imm_ext_s;
            rd_r           <= rd_s;
            result_src_r   <= result_src_s;
            reg_write_r    <= reg_write_s;
            mem_write_r    <= mem_write_s;
            mem_size_r     <= mem_size_s;
            mem_unsigned_r <= mem_unsigned_s;
        end
    end

    assign valid_m_o        = valid_r;
    assign alu_result_m_o   = alu_result_r;
    assign write_data_m_o   = write_data_r;
    assign pc_plus4_m_o     = pc_plus4_r;
    assign imm_ext_m_o      = imm_ext_r;
    assign rd_m_o           = rd_r;
    assign result_src_m_o   = result_src_r;
    assign reg_write_m_o    = reg_write_r;
    assign mem_write_m_o    = mem_write_r;
    assign mem_size_m_o     = mem_size_r;
    assign mem_unsigned_m_o = mem_unsigned_r;

    // Tap is decoded straight from the entry so a held entry keeps its forwarding state.
    assign rd_nonzero_s     = (rd_r != {REGISTER_WIDTH{1'b0}});
    assign fwd_data_m_o     = fwd_select(result_src_r, alu_result_r, pc_plus4_r, imm_ext_r);
    assign fwd_en_m_o       = valid_r & reg_write_r & rd_nonzero_s & (result_src_r != RES_MEM);
    assign load_pending_m_o = valid_r & reg_write_r & rd_nonzero_s & (result_src_r == RES_MEM);

    assign stall_inc_s  = stall_m_i & ~flush_m_i;
    assign bubble_inc_s = flush_m_i;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc_s),
        .count_o (stall_count_o)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_bubble_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bubble_inc_s),
        .count_o (bubble_count_o)
    );

endmodule

// File: tb/tb_execute_memory_pipe_reg.sv
// Bench for execute_memory_pipe_reg: directed cases then random traffic against a
// transaction-level model; a second instance with 3-bit counters covers saturation.
module tb_execute_memory_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 16;
    localparam int SW = 3;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [DW-1:0] pc4;
        logic [DW-1:0] imm;
        logic [RW-1:0] rd;
        logic [1:0]    src;
        logic          rw;
        logic          mw;
        logic [1:0]    size;
        logic          uns;
    } entry_t;

    logic clk, rst, stall, flush;
    logic valid_e, rw_e, mw_e, uns_e;
    logic [DW-1:0] alu_e, wd_e, pc4_e, imm_e;
    logic [RW-1:0] rd_e;
    logic [1:0] src_e, size_e;

    logic valid_m, rw_m, mw_m, uns_m, fwd_en, load_pend;
    logic [DW-1:0] alu_m, wd_m, pc4_m, imm_m, fwd_data;
    logic [RW-1:0] rd_m;
    logic [1:0] src_m, size_m;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    logic s_valid_m, s_rw_m, s_mw_m, s_uns_m, s_fwd_en, s_load_pend;
    logic [DW-1:0] s_alu_m, s_wd_m, s_pc4_m, s_imm_m, s_fwd_data;
    logic [RW-1:0] s_rd_m;
    logic [1:0] s_src_m, s_size_m;
    logic [SW-1:0] s_stall_cnt, s_bubble_cnt;

    entry_t m;
    int n_stall, n_bubble;
    int tests, fails;

    execute_memory_pipe_reg #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .stall_m_i(stall), .flush_m_i(flush), .valid_e_i(valid_e),
        .alu_result_e_i(alu_e), .write_data_e_i(wd_e), .pc_plus4_e_i(pc4_e), .imm_ext_e_i(imm_e),
        .rd_e_i(rd_e), .result_src_e_i(src_e), .reg_write_e_i(rw_e), .mem_write_e_i(mw_e),
        .mem_size_e_i(size_e), .mem_unsigned_e_i(uns_e), .valid_m_o(valid_m),
        .alu_result_m_o(alu_m), .write_data_m_o(wd_m), .pc_plus4_m_o(pc4_m), .imm_ext_m_o(imm_m),
        .rd_m_o(rd_m), .result_src_m_o(src_m), .reg_write_m_o(rw_m), .mem_write_m_o(mw_m),
        .mem_size_m_o(size_m), .mem_unsigned_m_o(uns_m), .fwd_data_m_o(fwd_data),
        .fwd_en_m_o(fwd_en), .load_pending_m_o(load_pend),
        .stall_count_o(stall_cnt), .bubble_count_o(bubble_cnt)
    );

    execute_memory_pipe_reg #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW), .COUNT_WIDTH(SW)) dut_small (
        .clk(clk), .rst(rst), .stall_m_i(stall), .flush_m_i(flush), .valid_e_i(valid_e),
        .alu_result_e_i(alu_e), .write_data_e_i(wd_e), .pc_plus4_e_i(pc4_e), .imm_ext_e_i(imm_e),
        .rd_e_i(rd_e), .result_src_e_i(src_e), .reg_write_e_i(rw_e), .mem_write_e_i(mw_e),
        .mem_size_e_i(size_e), .mem_unsigned_e_i(uns_e), .valid_m_o(s_valid_m),
        .alu_result_m_o(s_alu_m), .write_data_m_o(s_wd_m), .pc_plus4_m_o(s_pc4_m), .imm_ext_m_o(s_imm_m),
        .rd_m_o(s_rd_m), .result_src_m_o(s_src_m), .reg_write_m_o(s_rw_m), .mem_write_m_o(s_mw_m),
        .mem_size_m_o(s_size_m), .mem_unsigned_m_o(s_uns_m), .fwd_data_m_o(s_fwd_data),
        .fwd_en_m_o(s_fwd_en), .load_pending_m_o(s_load_pend),
        .stall_count_o(s_stall_cnt), .bubble_count_o(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Compare every output of the main instance (and the small instance's counters) to the model.
    task automatic check_all();
        logic [DW-1:0] exp_fwd;
        logic live;
        case (m.src)
            2'd2:    exp_fwd = m.pc4;
            2'd3:    exp_fwd = m.imm;
            default: exp_fwd = m.alu;
        endcase
        live = m.valid && m.rw && (m.rd != 5'd0);
        chk("valid", 32'(valid_m), 32'(m.valid));
        chk("alu_result", alu_m, m.alu);
        chk("write_data", wd_m, m.wd);
        chk("pc_plus4", pc4_m, m.pc4);
        chk("imm_ext", imm_m, m.imm);
        chk("rd", 32'(rd_m), 32'(m.rd));
        chk("result_src", 32'(src_m), 32'(m.src));
        chk("reg_write", 32'(rw_m), 32'(m.rw));
        chk("mem_write", 32'(mw_m), 32'(m.mw));
        chk("mem_size", 32'(size_m), 32'(m.size));
        chk("mem_unsigned", 32'(uns_m), 32'(m.uns));
        chk("fwd_data", fwd_data, exp_fwd);
        chk("fwd_en", 32'(fwd_en), 32'(live && (m.src != 2'd1)));
        chk("load_pending", 32'(load_pend), 32'(live && (m.src == 2'd1)));
        chk("stall_count", 32'(stall_cnt), 32'(sat(n_stall, CW)));
        chk("bubble_count", 32'(bubble_cnt), 32'(sat(n_bubble, CW)));
        chk("stall_count_w3", 32'(s_stall_cnt), 32'(sat(n_stall, SW)));
        chk("bubble_count_w3", 32'(s_bubble_cnt), 32'(sat(n_bubble, SW)));
    endtask

    // One clock: drive controls, advance the model by the EX->MEM rules, sample after the edge.
    task automatic step(input logic st, input logic fl);
        entry_t nxt;
        stall = st;
        flush = fl;
        nxt = m;
        if (fl) begin
            nxt = '0;
            n_bubble++;
        end else if (st) begin
            n_stall++;
        end else begin
            nxt = '{valid: valid_e, alu: alu_e, wd: wd_e, pc4: pc4_e, imm: imm_e, rd: rd_e,
                    src: src_e, rw: rw_e & valid_e, mw: mw_e & valid_e, size: size_e, uns: uns_e};
        end
        @(posedge clk);
        #1;
        m = nxt;
        check_all();
    endtask

    // Assert reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m = '0;
        n_stall = 0;
        n_bubble = 0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        valid_e = ($urandom_range(0, 3) != 0);
        alu_e   = $urandom;
        wd_e    = $urandom;
        pc4_e   = $urandom;
        imm_e   = $urandom;
        rd_e    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        src_e   = 2'($urandom_range(0, 3));
        rw_e    = 1'($urandom_range(0, 1));
        mw_e    = 1'($urandom_range(0, 1));
        size_e  = 2'($urandom_range(0, 2));
        uns_e   = 1'($urandom_range(0, 1));
    endtask

    task automatic set_op(input logic v, input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                          input logic [1:0] src, input logic rw, input logic mw);
        valid_e = v; alu_e = alu; rd_e = rd; src_e = src; rw_e = rw; mw_e = mw;
    endtask

    initial begin
        tests = 0; fails = 0; n_stall = 0; n_bubble = 0; m = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        valid_e = 1'b0; alu_e = 32'd0; wd_e = 32'd0; pc4_e = 32'd0; imm_e = 32'd0;
        rd_e = 5'd0; src_e = 2'd0; rw_e = 1'b0; mw_e = 1'b0; size_e = 2'd0; uns_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // normal flow
        set_op(1'b1, 32'h0000_1234, 5'd5, 2'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("nf_alu", alu_m, 32'h0000_1234);
        chk("nf_fwd_data", fwd_data, 32'h0000_1234);
        chk("nf_fwd_en", 32'(fwd_en), 32'd1);
        chk("nf_load_pending", 32'(load_pend), 32'd0);

        // three stalls with changing inputs, then flush with stall still high
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step(1'b1, 1'b0);
            chk("stall_hold_alu", alu_m, 32'h0000_1234);
            chk("stall_hold_fwd_en", 32'(fwd_en), 32'd1);
        end
        chk("stall3_count", 32'(stall_cnt), 32'd3);
        step(1'b1, 1'b1);
        chk("flush_valid", 32'(valid_m), 32'd0);
        chk("flush_reg_write", 32'(rw_m), 32'd0);
        chk("flush_bubble", 32'(bubble_cnt), 32'd1);
        chk("flush_stall_kept", 32'(stall_cnt), 32'd3);

        // load and x0 destination
        set_op(1'b1, 32'h0000_0040, 5'd7, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("load_pending", 32'(load_pend), 32'd1);
        chk("load_fwd_en", 32'(fwd_en), 32'd0);
        rd_e = 5'd0;
        step(1'b0, 1'b0);
        chk("x0_load_pending", 32'(load_pend), 32'd0);
        chk("x0_fwd_en", 32'(fwd_en), 32'd0);

        // forwarding sources and sub-word store
        set_op(1'b1, 32'h0000_0001, 5'd3, 2'd2, 1'b1, 1'b0);
        pc4_e = 32'h0000_0104;
        step(1'b0, 1'b0);
        chk("pc4_fwd", fwd_data, 32'h0000_0104);
        src_e = 2'd3;
        imm_e = 32'hFFFF_F000;
        step(1'b0, 1'b0);
        chk("imm_fwd", fwd_data, 32'hFFFF_F000);
        set_op(1'b1, 32'h0000_2002, 5'd0, 2'd0, 1'b0, 1'b1);
        size_e = 2'd1;
        uns_e = 1'b1;
        step(1'b0, 1'b0);
        chk("half_size", 32'(size_m), 32'd1);
        chk("half_unsigned", 32'(uns_m), 32'd1);
        chk("half_mem_write", 32'(mw_m), 32'd1);

        // invalid entry: data loads, controls suppressed
        set_op(1'b0, 32'h0000_BEEF, 5'd9, 2'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("inv_mem_write", 32'(mw_m), 32'd0);
        chk("inv_reg_write", 32'(rw_m), 32'd0);
        chk("inv_alu", alu_m, 32'h0000_BEEF);

        // reset mid-stream on a live register-writing entry
        set_op(1'b1, 32'h0000_5555, 5'd4, 2'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("pre_rst_valid", 32'(valid_m), 32'd1);
        do_reset();
        chk("rst_valid", 32'(valid_m), 32'd0);
        chk("rst_reg_write", 32'(rw_m), 32'd0);

        // saturation of the 3-bit counter
        for (int i = 0; i < 9; i++) begin
            rand_inputs();
            step(1'b1, 1'b0);
        end
        chk("sat_stall_w3", 32'(s_stall_cnt), 32'd7);
        chk("sat_stall_w16", 32'(stall_cnt), 32'd9);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/execute_memory_pipe_reg.md
# execute_memory_pipe_reg

Parametrised EX→MEM pipeline register for the five-stage core, sitting between the execute stage and data memory. It generalises the plain EX/MEM latch with:
- asynchronous reset
- stall (hold) and flush (bubble) control from the hazard unit
- a valid bit and sub-word memory access size
- a registered forwarding tap for the hazard unit
- saturating stall/bubble performance counters

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (ALU result, store data, PC+4, immediate).
- REGISTER_WIDTH, 5, register-index width.
- COUNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock, no other reset.
- stall_m_i  in  1  hold all pipeline fields this cycle.
- flush_m_i  in  1  load a bubble this cycle.
- valid_e_i  in  1  execute-stage instruction is real.
- alu_result_e_i, write_data_e_i, pc_plus4_e_i, imm_ext_e_i  in  DATA_WIDTH each  execute-stage data.
- rd_e_i  in  REGISTER_WIDTH  destination register.
- result_src_e_i  in  2  writeback source (result_src_t).
- reg_write_e_i, mem_write_e_i  in  1 each  control.
- mem_size_e_i  in  2  access size (mem_size_t: byte/half/word).
- mem_unsigned_e_i  in  1  zero-extend loads.
- valid_m_o  out  1  registered valid.
- alu_result_m_o, write_data_m_o, pc_plus4_m_o, imm_ext_m_o  out  DATA_WIDTH each  registered data.
- rd_m_o  out  REGISTER_WIDTH  registered destination register.
- result_src_m_o  out  2  registered writeback source.
- reg_write_m_o, mem_write_m_o  out  1 each  registered control.
- mem_size_m_o  out  2  registered access size.
- mem_unsigned_m_o  out  1  registered zero-extend flag.
- fwd_data_m_o  out  DATA_WIDTH  forwardable result of the MEM-stage instruction.
- fwd_en_m_o  out  1  fwd_data_m_o is usable for forwarding.
- load_pending_m_o  out  1  MEM-stage instruction is a register-writing load.
- stall_count_o, bubble_count_o  out  COUNT_WIDTH each  saturating counters.

## Operation
- Per-edge priority: rst (async) > flush_m_i > stall_m_i > normal load.
- Reset:
  - all outputs 0, so valid_m_o=0, reg_write_m_o=0, mem_write_m_o=0, result_src_m_o=RES_ALU, mem_size_m_o=SIZE_BYTE;
  - both counters 0.
- Flush:
  - valid_m_o, reg_write_m_o, mem_write_m_o ← 0;
  - data fields, rd, result_src, mem_size, mem_unsigned ← 0;
  - flush while stalled still bubbles.
- Stall (no flush): every pipeline field holds its value.
- Normal: every field ← its _e_i counterpart.
- reg_write_m_o and mem_write_m_o never assert while valid_m_o=0:
  - a loaded entry with valid_e_i=0 has both controls forced to 0;
  - its data fields still load.
- Forwarding tap (combinational from registered fields):
  - fwd_data_m_o = alu_result_m_o for RES_ALU/RES_MEM, pc_plus4_m_o for RES_PC4, imm_ext_m_o for RES_IMM.
  - fwd_en_m_o = valid_m_o & reg_write_m_o & (rd_m_o≠0) & (result_src_m_o≠RES_MEM).
  - load_pending_m_o = valid_m_o & reg_write_m_o & (rd_m_o≠0) & (result_src_m_o=RES_MEM).
- Counters:
  - stall_count_o +1 on each edge with stall_m_i=1 and flush_m_i=0;
  - bubble_count_o +1 on each edge with flush_m_i=1;
  - both saturate at 2^COUNT_WIDTH−1 and never wrap.

## Timing
- Latency 1 cycle from _e_i to _m_o.
- fwd_* and load_pending_m_o are valid in the same cycle as the registered fields; there is no extra register.
- rst assertion clears outputs immediately, without waiting for a clock edge.
- Deassertion is synchronised externally; the first load happens on the first edge after rst falls.
- stall_m_i and flush_m_i are sampled only at the rising edge.
- A held entry keeps fwd_en_m_o unchanged throughout the stall.

## Structure
- Package pipeline_pkg holds:
  - result_src_t: RES_ALU=0, RES_MEM=1, RES_PC4=2, RES_IMM=3;
  - mem_size_t: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
- Sub-module sat_counter (parameter WIDTH; ports clk, rst, inc_i, count_o) is instantiated twice.

## Test plan
- Reset mid-stream: assert rst between edges while valid_m_o=1, reg_write_m_o=1 → all outputs 0 immediately, counters 0.
- Normal flow: alu_result_e_i=0x0000_1234, rd_e_i=5, result_src_e_i=RES_ALU, reg_write_e_i=1, valid_e_i=1 → next cycle alu_result_m_o=0x1234, fwd_data_m_o=0x1234, fwd_en_m_o=1, load_pending_m_o=0.
- Stall then flush:
  - stall 3 cycles while inputs change → outputs held, stall_count_o=3;
  - then flush with stall still high → valid_m_o=0, reg_write_m_o=0, bubble_count_o=1, stall_count_o stays 3.
- Load and x0 cases:
  - result_src_e_i=RES_MEM, rd_e_i=7, reg_write_e_i=1 → load_pending_m_o=1, fwd_en_m_o=0;
  - same with rd_e_i=0 → both 0.
- Forwarding sources and sub-word store:
  - RES_PC4 with pc_plus4_e_i=0x104 → fwd_data_m_o=0x104;
  - RES_IMM with imm_ext_e_i=0xFFFF_F000 → fwd_data_m_o=0xFFFF_F000;
  - mem_size_e_i=SIZE_HALF, mem_unsigned_e_i=1 → passed through unchanged.
- Saturation and invalid entry:
  - COUNT_WIDTH=3, stall 9 cycles → stall_count_o=7;
  - valid_e_i=0 with mem_write_e_i=1 → mem_write_m_o=0.
